aer_spike_streamer: RTL

//  Synthesizable AER transmitter feeding the ODIN_ffstdp AERIN port (initiator side of the AERIN 4-phase link).

---
 rtl/aer_spike_streamer_if.sv | 28 ++
 rtl/aer_spike_streamer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/aer_spike_streamer_if.sv
// Bitmap load stream and AERIN 4-phase link between the spike streamer and its environment.
// master: the streamer (consumes bitmap bytes, initiates AER events); slave: loader + ODIN side.
interface aer_spike_streamer_if;
  logic [7:0]  load_data;
  logic        load_valid;
  logic        load_ready;
  logic [11:0] aerin_addr;
  logic        aerin_req;
  logic        aerin_ack;

  modport master (
    input  load_data,
    input  load_valid,
    input  aerin_ack,
    output load_ready,
    output aerin_addr,
    output aerin_req
  );

  modport slave (
    output load_data,
    output load_valid,
    output aerin_ack,
    input  load_ready,
    input  aerin_addr,
    input  aerin_req
  );
endinterface

// File: rtl/aer_spike_streamer.sv
// AER transmitter: buffers one time-step spike bitmap, emits one 4-phase event per set pixel plus a marker.
// Optional event counter enabled by defining AER_STREAMER_EVT_CNT_EN (default: EVT_COUNT tied to zero).
module aer_spike_streamer #(
  parameter int WIDTH     = 784,
  parameter int T         = 8,
  parameter int SETUP_CYC = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  aer_spike_streamer_if.master  bus_io,
  output logic [$clog2(T)-1:0]  tstep_o,
  output logic                  busy_o,
  output logic                  sample_done_o,
  output logic [15:0]           evt_count_o
);

  localparam int NB = WIDTH / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int PW = 11;
  localparam int SW = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
  localparam int TW = $clog2(T);

  localparam logic [11:0]   MARKER_ADDR = 12'h4FF;
  localparam logic [PW-1:0] PIX_END     = PW'(WIDTH);
  localparam logic [BW-1:0] BYTE_LAST   = BW'(NB - 1);
  localparam logic [SW-1:0] SETUP_LAST  = SW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] TSTEP_LAST  = TW'(T - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_SCAN,
    S_SETUP,
    S_WAIT_ACK,
    S_WAIT_NACK
  } state_t;

  state_t         state_q;
  logic [BW-1:0]  byte_ptr_q;
  logic [PW-1:0]  pix_ptr_q;
  logic [SW-1:0]  setup_cnt_q;
  logic           marker_q;
  logic [TW-1:0]  tstep_q;
  logic [11:0]    addr_q;
  logic           req_q;
  logic           load_ready_q;
  logic           busy_q;
  logic           sample_done_q;

  logic [7:0]     bitmap_q [NB];

  logic           load_fire;
  logic           pix_bit;
  logic           tstep_last;
  logic [PW-1:0]  pix_ptr_d;
  logic [BW-1:0]  byte_ptr_d;
  logic [TW-1:0]  tstep_d;

  assign load_fire  = (state_q == S_LOAD) && load_ready_q && bus_io.load_valid;
  // Byte k holds pixels 8k..8k+7 with the lowest pixel in bit 7, hence the inverted bit offset.
  assign pix_bit    = bitmap_q[pix_ptr_q[BW+2:3]][~pix_ptr_q[2:0]];
  assign tstep_last = (tstep_q == TSTEP_LAST);
  assign pix_ptr_d  = pix_ptr_q + PW'(1);
  assign byte_ptr_d = byte_ptr_q + BW'(1);
  assign tstep_d    = tstep_last ? '0 : tstep_q + TW'(1);

  always_ff @(posedge clk_i) begin
    if (load_fire) begin
      bitmap_q[byte_ptr_q] <= bus_io.load_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= S_LOAD;
      byte_ptr_q    <= '0;
      pix_ptr_q     <= '0;
      setup_cnt_q   <= '0;
      marker_q      <= 1'b0;
      tstep_q       <= '0;
      addr_q        <= '0;
      req_q         <= 1'b0;
      load_ready_q  <= 1'b1;
      busy_q        <= 1'b0;
      sample_done_q <= 1'b0;
    end else begin
      sample_done_q <= 1'b0;
      unique case (state_q)
        S_LOAD: begin
          if (load_fire) begin
            if (byte_ptr_q == BYTE_LAST) begin
              state_q      <= S_SCAN;
              load_ready_q <= 1'b0;
              busy_q       <= 1'b1;
              pix_ptr_q    <= '0;
            end else begin
              byte_ptr_q <= byte_ptr_d;
            end
          end
        end
        S_SCAN: begin
          if (pix_ptr_q == PIX_END) begin
            addr_q      <= MARKER_ADDR;
            marker_q    <= 1'b1;
            setup_cnt_q <= '0;
            state_q     <= S_SETUP;
          end else if (pix_bit) begin
            addr_q      <= {2'b00, pix_ptr_q[9:0]};
            marker_q    <= 1'b0;
            setup_cnt_q <= '0;
            state_q     <= S_SETUP;
          end else begin
            pix_ptr_q <= pix_ptr_d;
          end
        end
        S_SETUP: begin
          // REQ may only rise once ADDR has settled and the responder has released ACK.
          if ((setup_cnt_q == SETUP_LAST) && !bus_io.aerin_ack) begin
            req_q   <= 1'b1;
            state_q <= S_WAIT_ACK;
          end else if (setup_cnt_q != SETUP_LAST) begin
            setup_cnt_q <= setup_cnt_q + SW'(1);
          end
        end
        S_WAIT_ACK: begin
          if (bus_io.aerin_ack) begin
            req_q   <= 1'b0;
            state_q <= S_WAIT_NACK;
          end
        end
        S_WAIT_NACK: begin
          if (!bus_io.aerin_ack) begin
            if (marker_q) begin
              tstep_q       <= tstep_d;
              sample_done_q <= tstep_last;
              byte_ptr_q    <= '0;
              pix_ptr_q     <= '0;
              load_ready_q  <= 1'b1;
              busy_q        <= 1'b0;
              state_q       <= S_LOAD;
            end else begin
              pix_ptr_q <= pix_ptr_d;
              state_q   <= S_SCAN;
            end
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  assign bus_io.load_ready = load_ready_q;
  assign bus_io.aerin_addr = addr_q;
  assign bus_io.aerin_req  = req_q;
  assign tstep_o           = tstep_q;
  assign busy_o            = busy_q;
  assign sample_done_o     = sample_done_q;

`ifdef AER_STREAMER_EVT_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] evt_cnt_q;
  logic [15:0] evt_cnt_d;

  // The count is dropped on the same edge that raises SAMPLE_DONE.
  always_comb begin
    evt_cnt_d = evt_cnt_q;
    if ((state_q == S_WAIT_NACK) && !bus_io.aerin_ack && marker_q && tstep_last) begin
      evt_cnt_d = '0;
    end else if ((state_q == S_WAIT_ACK) && bus_io.aerin_ack && !marker_q) begin
      evt_cnt_d = sat_inc16(evt_cnt_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      evt_cnt_q <= '0;
    end else begin
      evt_cnt_q <= evt_cnt_d;
    end
  end

  assign evt_count_o = evt_cnt_q;
`else
  assign evt_count_o = 16'h0000;
`endif

endmodule
